// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive datapath (the TX side uses the same
// frame-format encoding).
//   rx_state_t      : receive FSM states
//   OVERSAMPLE      : baud_tick pulses per bit time
//   MID_SAMPLE      : tick count at which the start bit is re-checked
//   DATA_BITS_*     : data_bits register encoding (frame length 5..8)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  // Tick count at which data/parity/stop bits are sampled (one bit time
  // after the mid-start sample, so every sample lands mid-bit).
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  // Number of data bits in a frame for a given data_bits encoding.
  function automatic logic [3:0] data_bits_count(input logic [1:0] enc);
    return 4'(enc) + 4'd5;
  endfunction

endpackage

// File: rtl/uart_rx_datapath_if.sv
// Register/bus-side interface of the UART receive datapath.
//   data_bits/parity_en/parity_type : frame format (from control registers)
//   rx_queue_re / rx_queue_dout / rx_queue_empty / rx_queue_full : RX FIFO read port
//   err_clr / frame_err / parity_err / overrun_err : sticky error status
//   state_dbg : current receive FSM state, for observation only
// Read handshake: rx_queue_dout is valid whenever rx_queue_empty is low; asserting
// rx_queue_re for one clk in that condition pops the head at the next clock edge.
// rx_queue_re while empty is ignored.
interface uart_rx_datapath_if;
  import uart_pkg::*;

  logic [1:0] data_bits;
  logic       parity_en;
  logic       parity_type;
  logic       rx_queue_re;
  logic       err_clr;
  logic [7:0] rx_queue_dout;
  logic       rx_queue_empty;
  logic       rx_queue_full;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  rx_state_t  state_dbg;

  modport master (
    output data_bits, parity_en, parity_type, rx_queue_re, err_clr,
    input  rx_queue_dout, rx_queue_empty, rx_queue_full,
           frame_err, parity_err, overrun_err, state_dbg
  );

  modport slave (
    input  data_bits, parity_en, parity_type, rx_queue_re, err_clr,
    output rx_queue_dout, rx_queue_empty, rx_queue_full,
           frame_err, parity_err, overrun_err, state_dbg
  );

endinterface

// File: rtl/fifo.sv
// Synchronous FIFO, LENGTH entries of XLEN bits (LENGTH a power of two).
//   we/din  : write; ignored when full
//   re/dout : read; dout shows the head (zero when empty), re pops, ignored when empty
//   empty/full : occupancy status
// Fullness is judged before any same-cycle pop, so a write into a full FIFO
// is dropped even if a pop happens in that cycle.
module fifo #(
  parameter int XLEN   = 8,
  parameter int LENGTH = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [XLEN-1:0] din,
  input  logic            re,
  output logic [XLEN-1:0] dout,
  output logic            empty,
  output logic            full
);

  localparam int AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  logic [XLEN-1:0] mem [LENGTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_write;
  logic            do_read;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(LENGTH));
  assign do_write = we & ~full;
  assign do_read  = re & ~empty;
  assign dout     = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty masks stale contents from dout.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous input.
//   clk, reset_n : clock, asynchronous active-low reset
//   d            : asynchronous input
//   q            : synchronised output (2 clk latency)
// RESET_VAL presets both stages so the output does not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: synchronises rx, detects and frames characters on a
// 16x oversampling tick, checks parity/stop and queues good bytes.
//   clk, reset_n : clock, asynchronous active-low reset
//   rx           : asynchronous serial input, idle high
//   baud_tick    : 1-cycle strobe at 16x the baud rate
//   bus          : register-side interface (frame format, RX FIFO read, errors)
module uart_rx_datapath
  import uart_pkg::*;
#(
  parameter int RX_QUEUE_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  input  logic                baud_tick,
  uart_rx_datapath_if.slave   bus
);

  logic       rx_s;
  rx_state_t  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       par_err_q, par_err_d;
  logic [1:0] cfg_bits_q, cfg_bits_d;
  logic       cfg_par_en_q, cfg_par_en_d;
  logic       cfg_par_type_q, cfg_par_type_d;
  logic       push_q, push_d;
  logic [7:0] push_data_q, push_data_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;
  logic       overrun_err_q, overrun_err_d;
  logic       frame_set;
  logic       parity_set;
  logic       overrun_set;
  logic       fifo_full;
  logic       fifo_we;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Frame FSM and datapath. Everything moves only on baud_tick cycles.
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    par_d          = par_q;
    par_err_d      = par_err_q;
    cfg_bits_d     = cfg_bits_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_type_d = cfg_par_type_q;
    push_d         = 1'b0;
    push_data_d    = push_data_q;
    frame_set      = 1'b0;
    parity_set     = 1'b0;

    if (baud_tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d        = START;
            tick_cnt_d     = '0;
            // Format is frozen for the whole frame.
            cfg_bits_d     = bus.data_bits;
            cfg_par_en_d   = bus.parity_en;
            cfg_par_type_d = bus.parity_type;
          end
        end
        START: begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              par_d      = 1'b0;
              par_err_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d   = {rx_s, shift_q[7:1]};
            par_d     = par_q ^ rx_s;
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Last data bit is sample number data_bits+4 (0-based).
            if (bit_cnt_q == {1'b1, cfg_bits_q}) begin
              state_d = cfg_par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            par_err_d = ((par_q ^ rx_s) != cfg_par_type_q);
            state_d   = STOP;
          end
        end
        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            if (!rx_s) begin
              frame_set = 1'b1;
              state_d   = BREAK;
            end else if (par_err_q) begin
              parity_set = 1'b1;
              state_d    = IDLE;
            end else begin
              push_d      = 1'b1;
              // Data entered at bit 7, so short frames sit in the top bits.
              push_data_d = shift_q >> (2'd3 - cfg_bits_q);
              state_d     = IDLE;
            end
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky errors: a set in the same cycle wins over err_clr.
  assign overrun_set = push_q & fifo_full;
  assign fifo_we     = push_q & ~fifo_full;

  always_comb begin
    frame_err_d   = frame_set   | (frame_err_q   & ~bus.err_clr);
    parity_err_d  = parity_set  | (parity_err_q  & ~bus.err_clr);
    overrun_err_d = overrun_set | (overrun_err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      par_err_q      <= 1'b0;
      cfg_bits_q     <= DATA_BITS_8;
      cfg_par_en_q   <= 1'b0;
      cfg_par_type_q <= 1'b0;
      push_q         <= 1'b0;
      push_data_q    <= '0;
      frame_err_q    <= 1'b0;
      parity_err_q   <= 1'b0;
      overrun_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      par_err_q      <= par_err_d;
      cfg_bits_q     <= cfg_bits_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_type_q <= cfg_par_type_d;
      push_q         <= push_d;
      push_data_q    <= push_data_d;
      frame_err_q    <= frame_err_d;
      parity_err_q   <= parity_err_d;
      overrun_err_q  <= overrun_err_d;
    end
  end

  fifo #(
    .XLEN   (8),
    .LENGTH (RX_QUEUE_SIZE)
  ) u_rx_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (fifo_we),
    .din     (push_data_q),
    .re      (bus.rx_queue_re),
    .dout    (bus.rx_queue_dout),
    .empty   (bus.rx_queue_empty),
    .full    (fifo_full)
  );

  assign bus.rx_queue_full = fifo_full;
  assign bus.frame_err     = frame_err_q;
  assign bus.parity_err    = parity_err_q;
  assign bus.overrun_err   = overrun_err_q;
  assign bus.state_dbg     = state_q;

endmodule
